// File: rtl/ram_arbiter.sv
// Two-master RAM arbiter: CPU has priority, a waiting DMA preempts after
// STARVE_LIMIT cycles and a contended DMA burst is capped at DMA_BURST cycles.
module ram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned DMA_BURST    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_gnt,
   input  logic       dma_req,
   input  logic       dma_we,
   input  logic [7:0] dma_addr,
   input  logic [7:0] dma_wdata,
   output logic       dma_gnt,
   output logic [7:0] rdata,
   output logic [7:0] ram_addr,
   output logic       ram_we,
   output logic [7:0] ram_wdata,
   input  logic [7:0] ram_rdata,
   output logic [1:0] owner
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CPU  = 2'b01,
      DMA  = 2'b10
   } state_t;

   localparam logic [2:0] WAIT_MAX  = 3'(STARVE_LIMIT - 1);
   localparam logic [3:0] BURST_MAX = 4'(DMA_BURST - 1);

   state_t     state;
   state_t     nextState;
   logic [2:0] waitCnt;
   logic [3:0] burstCnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         waitCnt  <= '0;
         burstCnt <= '0;
      end else begin
         state <= nextState;
         // Counting only while staying in the owning state clears both
         // counters on any ownership change.
         if (state == CPU && dma_req && nextState == CPU && waitCnt != WAIT_MAX)
            waitCnt <= waitCnt + 3'd1;
         else if (state == CPU && dma_req && nextState == CPU)
            waitCnt <= waitCnt;
         else
            waitCnt <= '0;
         if (state == DMA && cpu_req && nextState == DMA)
            burstCnt <= burstCnt + 4'd1;
         else
            burstCnt <= '0;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (cpu_req)
               nextState = CPU;
            else if (dma_req)
               nextState = DMA;
         end
         CPU: begin
            if (!cpu_req)
               nextState = dma_req ? DMA : IDLE;
            else if (dma_req && waitCnt == WAIT_MAX)
               nextState = DMA;
         end
         DMA: begin
            if (!dma_req)
               nextState = cpu_req ? CPU : IDLE;
            else if (cpu_req && burstCnt == BURST_MAX)
               nextState = CPU;
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      unique case (state)
         CPU: begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we && cpu_req;
         end
         DMA: begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_we    = dma_we && dma_req;
         end
         default: begin
            ram_addr  = '0;
            ram_wdata = '0;
            ram_we    = 1'b0;
         end
      endcase
   end

   assign cpu_gnt = (state == CPU);
   assign dma_gnt = (state == DMA);
   assign owner   = state;
   assign rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with default parameters (STARVE_LIMIT=4,
// DMA_BURST=8); expected values are hand-derived from the arbitration rules.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_we, dma_req, dma_we;
   logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic       cpu_gnt, dma_gnt, ram_we;
   logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;
   logic [1:0] owner;

   int checks   = 0;
   int failures = 0;

   ram_arbiter #(.STARVE_LIMIT(4), .DMA_BURST(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt),
      .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h3C; dma_wdata = 8'h77;
      ram_rdata = 8'h00;

      // Reset overrides both requests
      tick(); tick();
      chk("rst_cpu_gnt", 8'(cpu_gnt), 8'h00);
      chk("rst_dma_gnt", 8'(dma_gnt), 8'h00);
      chk("rst_owner", 8'(owner), 8'h00);
      chk("rst_ram_we", 8'(ram_we), 8'h00);
      chk("rst_ram_addr", ram_addr, 8'h00);
      chk("rst_ram_wdata", ram_wdata, 8'h00);

      // CPU write, one-cycle grant latency
      reset = 1'b0; dma_req = 1'b0;
      tick();
      chk("cpuw_gnt", 8'(cpu_gnt), 8'h01);
      chk("cpuw_owner", 8'(owner), 8'h01);
      chk("cpuw_ram_we", 8'(ram_we), 8'h01);
      chk("cpuw_ram_addr", ram_addr, 8'h10);
      chk("cpuw_ram_wdata", ram_wdata, 8'hA5);

      cpu_req = 1'b0;
      tick();
      chk("idle_owner", 8'(owner), 8'h00);
      chk("idle_ram_we", 8'(ram_we), 8'h00);

      // Simultaneous requests: CPU first, DMA after 4 CPU cycles
      cpu_req = 1'b1; cpu_we = 1'b0; dma_req = 1'b1; dma_we = 1'b1;
      tick();
      chk("sim_owner_c1", 8'(owner), 8'h01);
      chk("sim_dma_gnt_c1", 8'(dma_gnt), 8'h00);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk($sformatf("starve_owner_c%0d", i), 8'(owner), 8'h01);
      end
      tick();
      chk("starve_owner_dma", 8'(owner), 8'h02);
      chk("starve_dma_gnt", 8'(dma_gnt), 8'h01);
      chk("starve_cpu_gnt", 8'(cpu_gnt), 8'h00);
      chk("dmaw_ram_we", 8'(ram_we), 8'h01);
      chk("dmaw_ram_addr", ram_addr, 8'h3C);
      chk("dmaw_ram_wdata", ram_wdata, 8'h77);

      // Uncontended DMA stays put
      cpu_req = 1'b0;
      tick(); tick(); tick();
      chk("dma_unbounded", 8'(owner), 8'h02);

      // CPU rises: DMA keeps 8 contended cycles, then CPU, then DMA after 4
      cpu_req = 1'b1;
      for (int i = 2; i <= 8; i++) begin
         tick();
         chk($sformatf("burst_owner_d%0d", i), 8'(owner), 8'h02);
      end
      tick();
      chk("burst_owner_cpu", 8'(owner), 8'h01);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk($sformatf("regain_owner_c%0d", i), 8'(owner), 8'h01);
      end
      tick();
      chk("regain_owner_dma", 8'(owner), 8'h02);

      // DMA read
      cpu_req = 1'b0; dma_we = 1'b0; ram_rdata = 8'h5A;
      #1;
      chk("dmar_rdata", rdata, 8'h5A);
      chk("dmar_ram_we", 8'(ram_we), 8'h00);
      chk("dmar_dma_gnt", 8'(dma_gnt), 8'h01);
      chk("dmar_ram_addr", ram_addr, 8'h3C);

      // DMA drops with CPU waiting -> CPU next cycle
      dma_req = 1'b0; cpu_req = 1'b1;
      tick();
      chk("d2c_owner", 8'(owner), 8'h01);
      // CPU drops with DMA waiting -> DMA with no idle gap
      dma_req = 1'b1; cpu_req = 1'b0;
      tick();
      chk("c2d_dma_gnt", 8'(dma_gnt), 8'h01);
      chk("c2d_cpu_gnt", 8'(cpu_gnt), 8'h00);

      // Reset mid DMA write
      dma_we = 1'b1;
      #1;
      chk("prerst_ram_we", 8'(ram_we), 8'h01);
      reset = 1'b1;
      tick();
      chk("midrst_owner", 8'(owner), 8'h00);
      chk("midrst_ram_we", 8'(ram_we), 8'h00);
      chk("midrst_dma_gnt", 8'(dma_gnt), 8'h00);
      reset = 1'b0;
      tick();
      chk("postrst_owner", 8'(owner), 8'h02);
      chk("postrst_dma_gnt", 8'(dma_gnt), 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: cycles a waiting DMA request tolerates while the CPU owns RAM before preemption (range 1..7).
REQ-002 Parameter DMA_BURST, default 8: maximum consecutive DMA-owned cycles while the CPU is requesting (range 1..15).
REQ-003 clk  in  1  single rising-edge clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-005 cpu_req  in  1  CPU requests RAM access.
REQ-006 cpu_we  in  1  CPU access is a write when high.
REQ-007 cpu_addr  in  8  CPU RAM address.
REQ-008 cpu_wdata  in  8  CPU write data.
REQ-009 cpu_gnt  out  1  CPU owns RAM this cycle.
REQ-010 dma_req  in  1  DMA/loader requests RAM access.
REQ-011 dma_we  in  1  DMA access is a write when high.
REQ-012 dma_addr  in  8  DMA RAM address.
REQ-013 dma_wdata  in  8  DMA write data.
REQ-014 dma_gnt  out  1  DMA owns RAM this cycle.
REQ-015 rdata  out  8  read data to current owner; combinational copy of ram_rdata.
REQ-016 ram_addr  out  8  RAM address.
REQ-017 ram_we  out  1  RAM write strobe, active high.
REQ-018 ram_wdata  out  8  RAM write data.
REQ-019 ram_rdata  in  8  RAM asynchronous read data.
REQ-020 owner  out  2  current state encoding: 00 IDLE, 01 CPU, 10 DMA; 11 never driven.

Function
REQ-021 Block SHALL implement three-state FSM IDLE/CPU/DMA held in a registered state; cpu_gnt=(state==CPU), dma_gnt=(state==DMA), both decoded from the register, never both high.
REQ-022 Grant latency SHALL be exactly 1 cycle: req high before edge n yields gnt high in the cycle following edge n.
REQ-023 A transfer SHALL occur in every cycle with req && gnt for the same requester; requester holds addr/we/wdata stable while req is high.
REQ-024 RAM port SHALL mux owner's addr/wdata combinationally; ram_we = owner_we && owner_req && owner_gnt; in IDLE ram_addr=0, ram_wdata=0, ram_we=0.
REQ-025 IDLE transitions: cpu_req -> CPU; else dma_req -> DMA; else stay; simultaneous requests -> CPU.
REQ-026 CPU transitions: cpu_req low -> DMA if dma_req else IDLE; cpu_req high and wait_cnt==STARVE_LIMIT-1 with dma_req high -> DMA; else stay.
REQ-027 wait_cnt (3-bit) SHALL increment each cycle in CPU with dma_req high, clear when dma_req low or on entering DMA, and never exceed STARVE_LIMIT-1.
REQ-028 DMA transitions: dma_req low -> CPU if cpu_req else IDLE; dma_req high, cpu_req high and burst_cnt==DMA_BURST-1 -> CPU; else stay.
REQ-029 burst_cnt (4-bit) SHALL increment each DMA cycle while cpu_req is high, clear when cpu_req low or on leaving DMA; DMA with no CPU contention is unbounded.
REQ-030 Request withdrawn in the same cycle as a handover SHALL not block the switch; owner change occurs only on clock edges.

Reset
REQ-031 reset high at posedge SHALL force state=IDLE, wait_cnt=0, burst_cnt=0, overriding all requests.
REQ-032 In the cycle after a reset edge: cpu_gnt=0, dma_gnt=0, owner=00, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-033 Reset asserted mid-transfer SHALL abort ownership; no ram_we pulse in the cycle after the reset edge.

Verification
REQ-034 Reset then cpu_req=1,cpu_we=1,addr=0x10,wdata=0xA5 -> cpu_gnt=1 next cycle, ram_we=1, ram_addr=0x10, ram_wdata=0xA5.
REQ-035 From IDLE, cpu_req=dma_req=1 same cycle -> owner=01; CPU holds; dma_gnt rises after exactly 4 CPU cycles (STARVE_LIMIT=4).
REQ-036 DMA owns, cpu_req rises and stays -> owner returns to 01 after 8 DMA cycles (DMA_BURST=8), then DMA regains after 4 more.
REQ-037 DMA read dma_addr=0x3C, ram_rdata=0x5A -> rdata=0x5A, ram_we=0, dma_gnt=1.
REQ-038 cpu_req drops while dma_req high -> dma_gnt=1 next cycle, cpu_gnt=0, no idle gap.
REQ-039 reset pulsed while owner=10 with dma_we=1 -> owner=00, ram_we=0 next cycle; re-grant to DMA one cycle after reset deasserts.
